// File: rtl/nibble_serial_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nibble_serial_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder stage reused by the nibble-serial adder.
module adder_4bit
  import nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);

  logic [NIBBLE_W:0] w_c;

  always_comb begin
    w_c[0] = i_cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams operands one nibble per clock through a single adder_4bit.
// Define NIBBLE_SERIAL_SIGNED_OVF_EN to report two's-complement overflow instead of carry-out.
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned WIDTH   = NIBBLE_W * NIBBLES
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int unsigned IDX_W = $clog2(NIBBLES);

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry, r_ovf, r_busy, r_done;
  logic               w_busy_d, w_done_d, w_last;
  logic [NIBBLE_W-1:0] w_a_nib, w_b_nib, w_nsum;
  logic               w_cout, w_ovf_final;

  assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_a_nib = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
  assign w_b_nib = r_b[NIBBLE_W*r_idx +: NIBBLE_W];

  adder_4bit u_adder (
    .i_a   (w_a_nib),
    .i_b   (w_b_nib),
    .i_cin (r_carry),
    .o_sum (w_nsum),
    .o_cout(w_cout)
  );

`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
  // On the last nibble w_nsum[NIBBLE_W-1] is the new sign bit of the full sum.
  assign w_ovf_final = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_nsum[NIBBLE_W-1] != r_a[WIDTH-1]);
`else
  assign w_ovf_final = w_cout;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_d = ADD;
      ADD:     if (w_last) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Flags follow the upcoming state so they line up with r_state after each edge.
  always_comb begin
    w_busy_d = (w_state_d == ADD);
    w_done_d = (w_state_d == DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= carry_in;
        r_idx   <= '0;
        r_sum   <= '0;
      end else if (r_state == ADD) begin
        r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_nsum;
        r_carry <= w_cout;
        if (w_last) begin
          r_ovf <= w_ovf_final;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        carry_in = 1'b0;
  logic        busy, done, overflow;
  logic [15:0] sum;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .carry_in(carry_in),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Launch one addition and watch 12 cycles; optionally fire a second start while busy.
  task automatic run_add(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic icin, input logic [15:0] esum, input logic eovf,
                         input bit inject);
    int busy_cnt, done_cnt, done_at;
    @(negedge clk);
    a = ia; b = ib; carry_in = icin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; carry_in = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
      if (inject && i == 2) begin
        start = 1'b1; a = 16'h0F0F; b = 16'h0F0F;
      end
      if (inject && i == 3) start = 1'b0;
    end
    check({tag, " done_cycle"}, done_at, 5);
    check({tag, " busy_cycles"}, busy_cnt, 4);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " sum"}, {16'h0, sum}, {16'h0, esum});
    check({tag, " overflow"}, {31'h0, overflow}, {31'h0, eovf});
  endtask

  initial begin
    int done_cnt;
    logic exp_wrap_ovf, exp_signed_ovf;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    exp_wrap_ovf   = 1'b0;
    exp_signed_ovf = 1'b1;
`else
    exp_wrap_ovf   = 1'b1;
    exp_signed_ovf = 1'b0;
`endif
    #12;
    check("rst busy", {31'h0, busy}, 0);
    check("rst done", {31'h0, done}, 0);
    check("rst sum", {16'h0, sum}, 0);
    check("rst overflow", {31'h0, overflow}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    run_add("basic", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_add("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, exp_wrap_ovf, 1'b0);
    run_add("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_add("signed", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, exp_signed_ovf, 1'b0);
    run_add("busy_start", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b1);
    run_add("after_busy", 16'h8001, 16'h8001, 1'b1, 16'h0003, 1'b1, 1'b0);

    // Abort an operation with an asynchronous reset partway through ADD.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("abort busy", {31'h0, busy}, 0);
    check("abort done", {31'h0, done}, 0);
    check("abort sum", {16'h0, sum}, 0);
    check("abort overflow", {31'h0, overflow}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no_done", done_cnt, 0);
    run_add("post_abort", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
